// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, transmitter state encoding and baud helper
package uart_pkg;
  localparam int UART_FRAME_BITS = 10;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with level/full/empty
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic we, re;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign we = wr_en && !full;
  assign re = rd_en && !empty;
  assign rd_data = mem[rp];
  // storage is written only on an accepted push; no reset needed for data
  always_ff @(posedge clk)
    if (we) mem[wp] <= wr_data;
  // pointers wrap naturally at DEPTH; level tracks push minus pop
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(we);
      rp <= rp + AW'(re);
      level <= level + (AW+1)'(we) - (AW+1)'(re);
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter draining a FWFT byte FIFO back-to-back
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW = CPB > 1 ? $clog2(CPB) : 1;
  localparam int IW = $clog2(UART_DATA_BITS);
  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [UART_DATA_BITS-1:0] sh, sh_n, rd_data;
  logic tx_n, done_n, pop, full, empty, term;
  assign s_ready = !rst && !full;
  assign busy = state != IDLE || fifo_level != '0;
  assign term = cnt == CW'(CPB - 1);
  sync_fifo #(.W(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(s_valid && s_ready),
    .wr_data(s_data),
    .rd_en(pop),
    .rd_data(rd_data),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  // next-state: bit timing, shifting, and popping the next byte at frame end
  always_comb begin
    state_n = state;
    cnt_n = term ? '0 : cnt + CW'(1);
    idx_n = idx;
    sh_n = sh;
    tx_n = tx;
    done_n = 1'b0;
    pop = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        tx_n = 1'b1;
        if (!empty) begin
          pop = 1'b1;
          sh_n = rd_data;
          tx_n = 1'b0;
          state_n = START;
        end
      end
      START:
        if (term) begin
          tx_n = sh[0];
          idx_n = '0;
          state_n = DATA;
        end
      DATA:
        if (term) begin
          if (idx == IW'(UART_DATA_BITS - 1)) begin
            tx_n = 1'b1;
            state_n = STOP;
          end else begin
            sh_n = sh >> 1;
            tx_n = sh[1];
            idx_n = idx + IW'(1);
          end
        end
      STOP:
        if (term) begin
          done_n = 1'b1;
          if (!empty) begin
            pop = 1'b1;
            sh_n = rd_data;
            tx_n = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
    endcase
  end
  // state register; reset truncates any frame and parks the line high
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      tx <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      tx <= tx_n;
      tx_done <= done_n;
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed self-checking bench for the buffered UART transmitter
module tb_uart_tx_buffered;
  localparam int CLK_FREQ = 800;
  localparam int BAUD = 100;
  localparam int DEPTH = 4;
  localparam int CPB = 8;
  localparam int LW = $clog2(DEPTH) + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, tx, busy, tx_done;
  logic [LW-1:0] fifo_level;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_done = 0;

  uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .tx(tx),
    .busy(busy),
    .tx_done(tx_done),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (tx_done === 1'b1) n_done++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic capture(input int pre, output logic [9:0] f);
    step(pre);
    f[0] = tx;
    for (int k = 1; k < 10; k++) begin
      step(CPB);
      f[k] = tx;
    end
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      step();
      ok = (tx === 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    step(2);
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready_in_rst: got %b want 0", s_ready); end
    rst = 1'b0;
    step();
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
    n_tests++; if (fifo_level !== LW'(0)) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_single();
    logic [9:0] f;
    step(3);
    s_data = 8'h55;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    s_data = 8'h00;
    n_tests++; if (fifo_level !== LW'(1)) begin n_fail++; $display("FAIL single_level_after_write: got %0d want 1", fifo_level); end
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_before_pop: got %b want 1", tx); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_queued: got %b want 1", busy); end
    step();
    n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL single_tx_start: got %b want 0", tx); end
    n_tests++; if (fifo_level !== LW'(0)) begin n_fail++; $display("FAIL single_level_after_pop: got %0d want 0", fifo_level); end
    capture(4, f);
    n_tests++; if (f !== 10'b1010101010) begin n_fail++; $display("FAIL single_frame: got %b want %b", f, 10'b1010101010); end
    step(3);
    n_tests++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL single_done_early: got %b want 0", tx_done); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_stop: got %b want 1", busy); end
    step();
    n_tests++; if (tx_done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", tx_done); end
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_idle: got %b want 1", tx); end
    step();
    n_tests++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b want 0", tx_done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [3] = '{8'hA3, 8'h00, 8'hFF};
    logic [9:0] f;
    int t0, d0;
    step(3);
    d0 = n_done;
    s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_data = b[k];
      step();
    end
    s_valid = 1'b0;
    t0 = cyc - 1;
    for (int k = 0; k < 3; k++) begin
      capture(k == 0 ? 3 : 4, f);
      n_tests++; if (f !== {1'b1, b[k], 1'b0}) begin n_fail++; $display("FAIL b2b_frame%0d: got %b want %b", k, f, {1'b1, b[k], 1'b0}); end
      step(3);
      n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL b2b_stop_len%0d: got %b want 1", k, tx); end
      step();
      n_tests++; if (tx_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done%0d: got %b want 1", k, tx_done); end
      n_tests++; if (tx !== (k < 2 ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL b2b_next_start%0d: got %b want %b", k, tx, (k < 2 ? 1'b0 : 1'b1)); end
    end
    n_tests++; if (cyc - t0 !== 240) begin n_fail++; $display("FAIL b2b_total_cycles: got %0d want 240", cyc - t0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    step();
    n_tests++; if (n_done - d0 !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 3", n_done - d0); end
  endtask

  task automatic test_fill();
    logic [7:0] b [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    int acc, max_lvl;
    bit hs;
    step(3);
    acc = 0;
    max_lvl = 0;
    fork
      begin
        s_valid = 1'b1;
        for (int t = 0; t < 2000 && acc < 6; t++) begin
          s_data = b[acc];
          @(negedge clk);
          hs = (s_ready === 1'b1);
          if (fifo_level === LW'(DEPTH)) begin
            n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_when_full: got %b want 0", s_ready); end
          end
          if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
          @(posedge clk);
          #1;
          if (hs) acc++;
        end
        s_valid = 1'b0;
      end
      begin
        logic [9:0] f;
        bit ok;
        for (int k = 0; k < 6; k++) begin
          wait_start(200, ok);
          n_tests++; if (!ok) begin n_fail++; $display("FAIL fill_start%0d: got timeout want start bit", k); break; end
          capture(4, f);
          n_tests++; if (f !== {1'b1, b[k], 1'b0}) begin n_fail++; $display("FAIL fill_frame%0d: got %b want %b", k, f, {1'b1, b[k], 1'b0}); end
          step(3);
        end
      end
    join
    n_tests++; if (acc !== 6) begin n_fail++; $display("FAIL fill_accepted: got %0d want 6", acc); end
    n_tests++; if (max_lvl !== DEPTH) begin n_fail++; $display("FAIL fill_max_level: got %0d want %0d", max_lvl, DEPTH); end
    step(4);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_full_pop();
    logic [7:0] b [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    step(3);
    s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_data = b[k];
      step();
    end
    n_tests++; if (fifo_level !== LW'(4)) begin n_fail++; $display("FAIL fullpop_level_full: got %0d want 4", fifo_level); end
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_ready_full: got %b want 0", s_ready); end
    s_data = 8'hEE;
    step(76);
    n_tests++; if (fifo_level !== LW'(4)) begin n_fail++; $display("FAIL fullpop_level_before_pop: got %0d want 4", fifo_level); end
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_ready_at_pop: got %b want 0", s_ready); end
    step();
    n_tests++; if (tx_done !== 1'b1) begin n_fail++; $display("FAIL fullpop_done: got %b want 1", tx_done); end
    n_tests++; if (fifo_level !== LW'(3)) begin n_fail++; $display("FAIL fullpop_level_after_pop: got %0d want 3", fifo_level); end
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_ready_after_pop: got %b want 1", s_ready); end
    step();
    s_valid = 1'b0;
    n_tests++; if (fifo_level !== LW'(4)) begin n_fail++; $display("FAIL fullpop_level_accept: got %0d want 4", fifo_level); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int d0, bad;
    step(3);
    s_valid = 1'b1;
    s_data = 8'h3C;
    step();
    s_data = 8'hA5;
    step();
    s_data = 8'h5A;
    step();
    s_valid = 1'b0;
    n_tests++; if (fifo_level !== LW'(2)) begin n_fail++; $display("FAIL rstmid_level_queued: got %0d want 2", fifo_level); end
    step(43);
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_bit4: got %b want 1", tx); end
    d0 = n_done;
    rst = 1'b1;
    step();
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    n_tests++; if (fifo_level !== LW'(0)) begin n_fail++; $display("FAIL rstmid_level: got %0d want 0", fifo_level); end
    n_tests++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", tx_done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_in_rst: got %b want 0", s_ready); end
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (tx !== 1'b1 || tx_done !== 1'b0 || fifo_level !== LW'(0) || busy !== 1'b0) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad); end
    n_tests++; if (n_done !== d0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", n_done - d0); end
  endtask

  task automatic test_reset_drop();
    int bad;
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h77;
    step();
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL drop_ready: got %b want 0", s_ready); end
    step();
    n_tests++; if (fifo_level !== LW'(0)) begin n_fail++; $display("FAIL drop_level: got %0d want 0", fifo_level); end
    rst = 1'b0;
    s_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (tx !== 1'b1 || fifo_level !== LW'(0) || busy !== 1'b0) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL drop_no_frame: got %0d active cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_full_pop();
    test_reset_mid();
    test_reset_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
